// File: rtl/controlador_display_pkg.sv
// Shared types and constants for the multiplexed 7-segment scan controller.
// The HEX_AN dark value is sliced from an 8-bit all-ones constant to N_DIG bits.
package controlador_display_pkg;

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_COMMIT = 2'd1,
        ST_BLANK  = 2'd2,
        ST_SHOW   = 2'd3
    } estado_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam int N_DIG_MAX = 8;
    localparam logic [N_DIG_MAX-1:0] AN_DARK_MAX = '1;

endpackage

// File: rtl/decodificador_7seg.sv
// Combinational hex to 7-segment decoder, active-low outputs {g,f,e,d,c,b,a}.
module decodificador_7seg
    import controlador_display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/controlador_display.sv
// Scan controller for an N_DIG common-anode display with frame-synchronous digit commit.
// Optional leading-zero blanking is enabled with `define DISPLAY_ZERO_SUPPRESS_EN.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_OFF    | display dark, waiting for en
// ST_COMMIT | shadow copied to active at cycle end, frame pulse, writes stalled
// ST_BLANK  | GAP dark cycles before the next digit
// ST_SHOW   | digit k lit for DIV cycles
module controlador_display
    import controlador_display_pkg::*;
#(
    parameter int N_DIG = 4,
    parameter int DIV   = 50000,
    parameter int GAP   = 16
) (
    input  logic                      CLOCK_50,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(N_DIG)-1:0]  wr_idx,
    input  logic [3:0]                wr_data,
    output logic [6:0]                HEX_SEG,
    output logic [N_DIG-1:0]          HEX_AN,
    output logic                      frame
);

    localparam int IDX_W = $clog2(N_DIG);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [N_DIG-1:0] AN_DARK  = AN_DARK_MAX[N_DIG-1:0];
    localparam logic [IDX_W-1:0] K_LAST   = IDX_W'(N_DIG - 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

    estado_t          state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [DIV_W-1:0] show_cnt_q, show_cnt_d;
    logic [GAP_W-1:0] blank_cnt_q, blank_cnt_d;
    logic [3:0]       shadow_q [N_DIG];
    logic [3:0]       shadow_d [N_DIG];
    logic [3:0]       active_q [N_DIG];
    logic [3:0]       active_d [N_DIG];
    logic [6:0]       seg_q, seg_d, seg_dec;
    logic [N_DIG-1:0] an_q, an_d;
    logic             frame_q, frame_d;
    logic             ready_q, ready_d;
    logic             wr_fire;
    logic             suppress;
    logic [3:0]       dig_sel;

    assign wr_fire = wr_valid & ready_q;

    always_ff @(posedge CLOCK_50) begin
        if (!rst_n) begin
            state_q     <= ST_OFF;
            k_q         <= '0;
            show_cnt_q  <= '0;
            blank_cnt_q <= '0;
            shadow_q    <= '{default: '0};
            active_q    <= '{default: '0};
            seg_q       <= SEG_BLANK;
            an_q        <= AN_DARK;
            frame_q     <= 1'b0;
            ready_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            show_cnt_q  <= show_cnt_d;
            blank_cnt_q <= blank_cnt_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frame_q     <= frame_d;
            ready_q     <= ready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        show_cnt_d  = show_cnt_q;
        blank_cnt_d = blank_cnt_q;
        shadow_d    = shadow_q;
        active_d    = active_q;

        // Indices beyond N_DIG match no entry, so such writes are accepted and dropped.
        if (wr_fire) begin
            for (int i = 0; i < N_DIG; i++) begin
                if (wr_idx == IDX_W'(i)) shadow_d[i] = wr_data;
            end
        end

        if (state_q == ST_COMMIT) active_d = shadow_q;

        if (!en) begin
            state_d     = ST_OFF;
            k_d         = '0;
            show_cnt_d  = '0;
            blank_cnt_d = '0;
        end else begin
            case (state_q)
                ST_OFF: state_d = ST_COMMIT;
                ST_COMMIT: begin
                    state_d     = ST_BLANK;
                    k_d         = '0;
                    blank_cnt_d = GAP_LOAD;
                end
                ST_BLANK: begin
                    if (blank_cnt_q == '0) begin
                        state_d    = ST_SHOW;
                        show_cnt_d = DIV_LOAD;
                    end else begin
                        blank_cnt_d = blank_cnt_q - 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (show_cnt_q == '0) begin
                        if (k_q == K_LAST) begin
                            state_d = ST_COMMIT;
                        end else begin
                            state_d     = ST_BLANK;
                            k_d         = k_q + 1'b1;
                            blank_cnt_d = GAP_LOAD;
                        end
                    end else begin
                        show_cnt_d = show_cnt_q - 1'b1;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Outputs are computed from next-state values so they update on the same edge as the FSM.
    assign dig_sel = active_d[k_d];

    decodificador_7seg u_dec (
        .nibble (dig_sel),
        .seg    (seg_dec)
    );

    always_comb begin
        suppress = 1'b0;
`ifdef DISPLAY_ZERO_SUPPRESS_EN
        suppress = (k_d != '0);
        for (int i = 0; i < N_DIG; i++) begin
            if ((IDX_W'(i) >= k_d) && (active_d[i] != 4'd0)) suppress = 1'b0;
        end
`endif
        frame_d = (state_d == ST_COMMIT);
        ready_d = (state_d != ST_COMMIT);
        an_d    = AN_DARK;
        seg_d   = SEG_BLANK;
        if (state_d == ST_SHOW) begin
            an_d  = ~(N_DIG'(1) << k_d);
            seg_d = suppress ? SEG_BLANK : seg_dec;
        end
    end

    assign HEX_SEG  = seg_q;
    assign HEX_AN   = an_q;
    assign frame    = frame_q;
    assign wr_ready = ready_q;

endmodule

// File: tb/tb_controlador_display.sv
// Directed self-checking bench for controlador_display with N_DIG=4, DIV=4, GAP=2.
module tb_controlador_display;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SX = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_idx;
    logic [3:0] wr_data;
    logic [6:0] HEX_SEG;
    logic [3:0] HEX_AN;
    logic       frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    controlador_display #(.N_DIG(4), .DIV(4), .GAP(2)) dut (
        .CLOCK_50 (clk),
        .rst_n    (rst_n),
        .en       (en),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_idx   (wr_idx),
        .wr_data  (wr_data),
        .HEX_SEG  (HEX_SEG),
        .HEX_AN   (HEX_AN),
        .frame    (frame)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_dark(input string tag);
        chk({tag, "_an"}, HEX_AN, 4'hF);
        chk({tag, "_seg"}, HEX_SEG, SX);
        chk({tag, "_frame"}, frame, 1'b0);
        chk({tag, "_ready"}, wr_ready, 1'b1);
    endtask

    task automatic check_commit();
        tick();
        chk("commit_frame", frame, 1'b1);
        chk("commit_ready", wr_ready, 1'b0);
        chk("commit_an", HEX_AN, 4'hF);
        chk("commit_seg", HEX_SEG, SX);
    endtask

    // Checks the 24 cycles after a COMMIT; segs = {d3,d2,d1,d0}.
    // wr_valid is driven for edges t in [wr_t0, wr_t1) counted from the call.
    task automatic scan_frame(input logic [27:0] segs, input int wr_t0, input int wr_t1,
                              input logic [1:0] idx, input logic [3:0] data);
        logic [3:0] an_exp;
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 6; c++) begin
                wr_valid = ((d * 6 + c) >= wr_t0) && ((d * 6 + c) < wr_t1);
                wr_idx   = idx;
                wr_data  = data;
                tick();
                if (c < 2) begin
                    chk_dark("scan_gap");
                end else begin
                    an_exp = ~(4'b0001 << d);
                    chk("scan_an", HEX_AN, an_exp);
                    chk("scan_seg", HEX_SEG, segs[d*7 +: 7]);
                    chk("scan_frame", frame, 1'b0);
                    chk("scan_ready", wr_ready, 1'b1);
                end
            end
        end
        wr_valid = 1'b0;
    endtask

    task automatic write_off(input logic [1:0] idx, input logic [3:0] data);
        wr_valid = 1'b1;
        wr_idx   = idx;
        wr_data  = data;
        tick();
        wr_valid = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b1;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_data  = '0;

        // Reset with en high
        tick();
        tick();
        chk("rst_an", HEX_AN, 4'hF);
        chk("rst_seg", HEX_SEG, SX);
        chk("rst_frame", frame, 1'b0);
        chk("rst_ready", wr_ready, 1'b1);

        en    = 1'b0;
        rst_n = 1'b1;
        tick();
        chk_dark("off");

        // Scan order
        write_off(2'd0, 4'd1);
        write_off(2'd1, 4'd2);
        write_off(2'd2, 4'd3);
        write_off(2'd3, 4'd4);
        chk_dark("off_after_writes");
        en = 1'b1;
        check_commit();
        scan_frame({S4, S3, S2, S1}, 99, 99, 2'd0, 4'd0);

        // Tear-free update of digit 0 during the frame's first blank
        check_commit();
        scan_frame({S4, S3, S2, S1}, 1, 2, 2'd0, 4'd8);

        // Write held across COMMIT: stalled, then taken on the next edge
        check_commit();
        scan_frame({S4, S3, S2, S8}, 0, 2, 2'd1, 4'hC);
        check_commit();
        scan_frame({S4, S3, SC, S8}, 99, 99, 2'd0, 4'd0);

        // Enable drop during digit 2 SHOW
        check_commit();
        for (int t = 0; t < 14; t++) tick();
        tick();
        chk("d2_an", HEX_AN, 4'b1011);
        chk("d2_seg", HEX_SEG, S3);
        en = 1'b0;
        tick();
        chk_dark("en_drop");
        tick();
        tick();
        chk_dark("en_low");
        en = 1'b1;
        check_commit();
        scan_frame({S4, S3, SC, S8}, 99, 99, 2'd0, 4'd0);

        // Zero suppression, last write coinciding with en rising in OFF
        en = 1'b0;
        tick();
        chk_dark("off2");
        write_off(2'd0, 4'd0);
        write_off(2'd1, 4'd5);
        write_off(2'd2, 4'd0);
        en       = 1'b1;
        wr_valid = 1'b1;
        wr_idx   = 2'd3;
        wr_data  = 4'd0;
        check_commit();
`ifdef DISPLAY_ZERO_SUPPRESS_EN
        scan_frame({SX, SX, S5, S0}, 99, 99, 2'd0, 4'd0);
`else
        scan_frame({S0, S0, S5, S0}, 99, 99, 2'd0, 4'd0);
`endif

        // Reset mid-frame discards pending shadow writes
        check_commit();
        tick();
        tick();
        wr_valid = 1'b1;
        wr_idx   = 2'd2;
        wr_data  = 4'd7;
        tick();
        wr_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk_dark("rst_mid");
        rst_n = 1'b1;
        check_commit();
`ifdef DISPLAY_ZERO_SUPPRESS_EN
        scan_frame({SX, SX, SX, S0}, 99, 99, 2'd0, 4'd0);
`else
        scan_frame({S0, S0, S0, S0}, 99, 99, 2'd0, 4'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controlador_display.md
# controlador_display

Time-multiplexed scan controller that shares one hex-to-7-segment decoder among `N_DIG` digit positions of a common-anode display. Writers load 4-bit digit values through a valid/ready port into shadow registers. Values are committed to the active set only at frame boundaries, so the display never tears. The block sits between user logic (switch/counter datapaths) and the board segment/anode pins.

## Interface
Parameters:
- `N_DIG`, default 4: number of digit positions (2..8).
- `DIV`, default 50000: clock cycles each digit is lit per scan slot (≥1).
- `GAP`, default 16: all-off cycles between slots, for anti-ghosting (≥1).

Ports:
- `CLOCK_50`  in  1: system clock; all logic on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `en`  in  1: display enable.
- `wr_valid`  in  1: write request.
- `wr_ready`  out  1: write accepted when `wr_valid & wr_ready`.
- `wr_idx`  in  `$clog2(N_DIG)`: target digit.
- `wr_data`  in  4: nibble value.
- `HEX_SEG`  out  7: segments `{g,f,e,d,c,b,a}`, active-low.
- `HEX_AN`  out  `N_DIG`: digit enables, active-low one-hot.
- `frame`  out  1: one-cycle pulse in each COMMIT cycle.

## Operation
- States:
  - OFF: outputs dark.
  - COMMIT: copy shadow→active, pulse `frame`, `wr_ready=0`.
  - BLANK: GAP cycles, outputs dark.
  - SHOW: DIV cycles, digit `k` lit.
- Transitions:
  - Reset→OFF.
  - OFF→COMMIT when `en=1`.
  - COMMIT→BLANK with `k=0`.
  - BLANK→SHOW after GAP cycles.
  - SHOW→BLANK with `k+1` after DIV cycles if `k<N_DIG-1`, else SHOW→COMMIT.
  - Any state→OFF when `en=0`; `k` and both counters clear.
- In SHOW: `HEX_AN` bit `k` is 0 and all others are 1; `HEX_SEG = decode(active[k])`.
- Writes:
  - Accepted in every state except COMMIT; stored in `shadow[wr_idx]` on the accept edge.
  - `wr_idx ≥ N_DIG`: accepted and dropped.
  - A write on the same edge as COMMIT is not accepted; the writer holds `wr_valid`.
- Reset values: `HEX_AN` all 1, `HEX_SEG=7'b1111111`, `frame=0`, `wr_ready=1`, shadow/active all 0, `k=0`, state OFF.
- Dark means `HEX_AN` all 1 and `HEX_SEG` all 1.

## Timing
- All outputs are registered and change on the same edge as the state register.
- Frame period with `en` held high: `N_DIG*(GAP+DIV)+1` cycles.
- `frame` is high exactly one cycle per frame.
- Write-to-display latency: a value is shown from the first SHOW of that digit after the next COMMIT.
- Reset mid-frame: outputs are dark on the edge after `rst_n` is sampled low, and pending shadow writes are lost.
- `en` falling mid-SHOW: dark on the next edge. Re-enable always restarts at COMMIT, then digit 0.
- `en` and `wr_valid` rising together in OFF: the write lands in shadow on that edge, COMMIT runs on the following edge, and the value is displayed in the first frame.
- Counter widths: `$clog2(DIV)` and `$clog2(GAP)`. Counters wrap only through the state transition, never by overflow.

## Configuration
- `DISPLAY_ZERO_SUPPRESS_EN` defined:
  - Leading zeros are blanked. Scanning from index `N_DIG-1` downward, every active digit equal to 0 up to the first nonzero digit shows `HEX_SEG=7'b1111111`.
  - Its anode still follows normal timing.
  - Digit 0 is never suppressed.
- `DISPLAY_ZERO_SUPPRESS_EN` undefined: every digit shows its decoded value.
- Suppression is evaluated from the active set, never from shadow.

## Structure
- Package `controlador_display_pkg` holds:
  - state enum (`ST_OFF`, `ST_COMMIT`, `ST_BLANK`, `ST_SHOW`);
  - `SEG_BLANK = 7'b1111111`;
  - the all-1 dark value for `HEX_AN` (`N_DIG`-wide, built from the parameter).
- One sub-module, `decodificador_7seg`: combinational 4-bit→7-bit active-low hex decoder, standard glyphs 0–F. Examples: 0→`7'b1000000`, 1→`7'b1111001`, 5→`7'b0010010`, 8→`7'b0000000`.
- The controller owns the FSM, counters, shadow/active arrays and output registers.

## Test plan
Bench parameters: `N_DIG=4`, `DIV=4`, `GAP=2`.
1. Reset: hold `rst_n=0` for 2 cycles with `en=1` → `HEX_AN=4'b1111`, `HEX_SEG=7'b1111111`, `frame=0`, `wr_ready=1`.
2. Scan order: write 1, 2, 3, 4 to idx 0–3, then raise `en`.
   - `frame` pulses with `wr_ready=0`, followed by 2 dark cycles.
   - `HEX_AN=4'b1110` with `HEX_SEG=7'b1111001` for 4 cycles, then 2 dark cycles, then `4'b1101`, and so on.
   - `frame` repeats every 25 cycles.
3. Tear-free: write 8 to idx 0 mid-frame → digit 0 keeps showing 1 until the next `frame`, then shows `7'b0000000`.
4. Write collision: hold `wr_valid` across a COMMIT cycle → not accepted in COMMIT, accepted on the next cycle, value lands in shadow.
5. Enable drop: lower `en` in SHOW of digit 2 → dark on the next edge. Re-raise `en` → `frame` pulse, then digit 0 first.
6. Zero suppress: active values idx3..0 = 0, 0, 5, 0.
   - With the macro: digits 3 and 2 show `7'b1111111`, digit 1 shows `7'b0010010`, digit 0 shows `7'b1000000`.
   - Without the macro: digits 3 and 2 show `7'b1000000`.
